// File: rtl/psm_waddr_gen.sv
// psm_waddr_gen: SRAMC write-address generator for the PSM write-back path.
// Walks a run of i_n_elems elements starting at slot i_start_ofs of SRAMC
// word i_base_addr. Each issue cycle emits a contiguous slot mask that
// never straddles a FIFO word (Y elements) or an SRAMC word (SRAMC_N slots),
// and marks the FIFO pop when the current FIFO word is consumed.
//
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_start                launch pulse (accepted only in IDLE)
//   i_base_addr/i_start_ofs/i_n_elems  transfer descriptor
//   i_feeder_en            global pipeline enable (stall when low)
//   i_fifo_empty           no FIFO word available
//   o_mask, o_fifo_pop     issue-cycle mask / FIFO word transition
//   o_clearbuff            element-counter clear, in the launch cycle
//   o_sramc_addr/o_sramc_wen  issue address + write enable, 2 stages late
//   o_busy, o_done         transfer status / one-cycle completion pulse
module psm_waddr_gen #(
    parameter int Y       = 3,
    parameter int SRAMC_N = 2,
    parameter int ADR_W   = 10,
    parameter int CNT_W   = 16,
    localparam int SW     = (SRAMC_N > 1) ? $clog2(SRAMC_N) : 1,
    localparam int IW     = $clog2(Y + 1)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [ADR_W-1:0]   i_base_addr,
    input  logic [SW-1:0]      i_start_ofs,
    input  logic [CNT_W-1:0]   i_n_elems,
    input  logic               i_feeder_en,
    input  logic               i_fifo_empty,
    output logic [0:SRAMC_N-1] o_mask,
    output logic               o_fifo_pop,
    output logic               o_clearbuff,
    output logic [ADR_W-1:0]   o_sramc_addr,
    output logic               o_sramc_wen,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            slot_q;
    logic [IW-1:0]            iw_q;
    logic [CNT_W-1:0]         rem_q;
    logic [ADR_W-1:0]         addr_q;
    logic                     drain_q;
    logic [2:1]               vld_pipe;
    logic [2:1][ADR_W-1:0]    addr_pipe;

    logic                     launch, issue, pop, slot_end;
    logic [CNT_W-1:0]         slot_ext, room_s, room_w, step, rem_nxt;
    logic [0:SRAMC_N-1]       mask;

    // A start pulse is taken in IDLE even during a stall: it is a single
    // cycle wide and would otherwise be lost.
    assign launch = (state_q == S_IDLE) && i_start;
    assign issue  = (state_q == S_RUN) && i_feeder_en && !i_fifo_empty;

    always_comb begin
        slot_ext = CNT_W'(slot_q);
        room_s   = CNT_W'(SRAMC_N) - slot_ext;
        room_w   = CNT_W'(Y) - CNT_W'(iw_q);
        step     = (room_s < room_w) ? room_s : room_w;
        if (rem_q < step) step = rem_q;
        rem_nxt  = rem_q - step;
        pop      = issue && ((CNT_W'(iw_q) + step == CNT_W'(Y)) || (rem_nxt == '0));
        slot_end = (slot_ext + step == CNT_W'(SRAMC_N));
        for (int i = 0; i < SRAMC_N; i++)
            mask[i] = issue && (CNT_W'(i) >= slot_ext) && (CNT_W'(i) < slot_ext + step);
    end

    // Every transition out of RUN/DRAIN/DONE is qualified by i_feeder_en,
    // so a stall freezes the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = (i_n_elems == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issue && rem_nxt == '0) state_d = S_DRAIN;
            S_DRAIN: if (i_feeder_en && drain_q) state_d = S_DONE;
            S_DONE:  if (i_feeder_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            iw_q    <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                slot_q  <= i_start_ofs;
                iw_q    <= '0;
                rem_q   <= i_n_elems;
                addr_q  <= i_base_addr;
                drain_q <= 1'b0;
            end else if (issue) begin
                rem_q <= rem_nxt;
                iw_q  <= pop ? '0 : IW'(CNT_W'(iw_q) + step);
                if (slot_end) begin
                    slot_q <= '0;
                    addr_q <= addr_q + ADR_W'(1);
                end else begin
                    slot_q <= SW'(slot_ext + step);
                end
            end
            // drain_q counts the two enabled DRAIN cycles (0 then 1).
            if (state_q == S_DRAIN && i_feeder_en)
                drain_q <= ~drain_q;
        end
    end

    // Address/enable delay line matching the wdata_manager mask latency.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (i_feeder_en) begin
            vld_pipe[1]  <= |mask;
            vld_pipe[2]  <= vld_pipe[1];
            addr_pipe[1] <= addr_q;
            addr_pipe[2] <= addr_pipe[1];
        end
    end

    assign o_mask       = mask;
    assign o_fifo_pop   = pop;
    // Gated by reset so every output is 0 while i_rstn is low.
    assign o_clearbuff  = i_rstn && launch;
    assign o_sramc_addr = addr_pipe[2];
    assign o_sramc_wen  = vld_pipe[2];
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE) && i_feeder_en;

endmodule
